al_accel_cp_seq: RTL and testbench
==================================

Name: al_accel_cp_seq

Overview:
Sequencer that drives the al_accel_cp_unit pooling/compare datapath in the accelerator. It walks a source buffer in non-overlapping windows and streams each window into the CP unit. Around each window it issues cp_clr/enb, captures the per-window result and writes it to a destination buffer. Sits between the accelerator register/command block (start/config/done) and the local SRAM buffers plus the CP unit.

Parameters:
DATA_W, 8, width of buffer data, cp_di and cp_do
ADDR_W, 10, buffer address width; addresses wrap mod 2^ADDR_W
WIN_W, 4, width of window-length field (max window 2^WIN_W-1)
NWIN_W, 8, width of window-count field

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; accepted only in IDLE
abort  in  1  synchronous abort; highest priority
cfg_src_base  in  ADDR_W  first source address
cfg_dst_base  in  ADDR_W  first destination address
cfg_win_len  in  WIN_W  elements per window L (valid 1..2^WIN_W-1)
cfg_num_win  in  NWIN_W  window count N (valid 1..2^NWIN_W-1)
busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive
done  out  1  one-cycle pulse at end of job or on cfg error
err  out  1  sticky cfg-error flag, cleared by the next accepted start
rd_en  out  1  source buffer read strobe
rd_addr  out  ADDR_W  source read address
rd_data  in  DATA_W  source data, valid exactly 1 cycle after rd_en
cp_di  out  DATA_W  data to CP unit
cp_enb  out  1  CP unit enable; high only when cp_di is valid
cp_clr  out  1  CP unit accumulator clear
cp_do  in  DATA_W  CP result, valid the cycle after the last cp_enb of a window
wr_en  out  1  destination buffer write strobe
wr_addr  out  ADDR_W  destination address
wr_data  out  DATA_W  destination data

Behaviour:
- Reset (resetn=0, async): state=IDLE. busy, done, err, rd_en, cp_enb, cp_clr and wr_en are 0. rd_addr, wr_addr, wr_data and cp_di are 0. All counters are 0.
- FSM states: IDLE, CLR, FEED, TAIL, WRITE, DONE.
- IDLE, start=1: latch all cfg_* inputs.
  - If L==0 or N==0: go to DONE with err=1.
  - Otherwise: err=0, window index k=0, go to CLR.
- IDLE, start=0: stay in IDLE.
- CLR (1 cycle): cp_clr=1, cp_enb=0. Element counter i=0. Go to FEED.
- FEED (L cycles): rd_en=1, rd_addr=src_base+k*L+i (mod 2^ADDR_W), i increments each cycle. After i reaches L-1, go to TAIL.
- Data alignment: one cycle after each rd_en, cp_enb=1 and cp_di=rd_data (registered path). cp_enb is therefore high for exactly L consecutive cycles per window, starting the cycle after CLR+1.
- TAIL (1 cycle): last cp_enb of the window.
- WRITE (1 cycle): wr_en=1, wr_addr=dst_base+k (mod 2^ADDR_W), wr_data=cp_do. Then:
  - if k==N-1, go to DONE;
  - else k++ and go to CLR.
- Window timing: L+3 cycles per window. Job time from start accept to done is N*(L+3)+1 cycles.
- DONE (1 cycle): done=1, busy=1 if the job ran (busy=0 on the cfg-error path). Then go to IDLE.
- start while not in IDLE: ignored; latched config is unchanged.
- abort=1 in any non-IDLE state:
  - next cycle: state=IDLE, cp_clr=1 for one cycle, rd_en=cp_enb=wr_en=0, busy=0;
  - no done pulse is issued;
  - a read already in flight is discarded, not fed to the CP unit.
- abort and start in the same cycle in IDLE: abort wins and start is dropped.
- resetn asserted mid-job: outputs return to reset values immediately; the partially written destination is left as-is.
- Address arithmetic: done at ADDR_W bits with carry discarded (wrap-around). k*L is computed in an ADDR_W-bit product.

Decomposition:
- Shared package al_accel_pkg: the state encoding enum (IDLE..DONE), the widths DATA_W/ADDR_W/WIN_W/NWIN_W as default constants, and a cfg struct {src_base, dst_base, win_len, num_win}.
- One natural sub-module: al_accel_cp_addr_gen. It holds the i/k counters and produces rd_addr/wr_addr, the last-element flag and the last-window flag. The FSM and data-alignment register stay in the top module.

Test Plan:
- Single window: src_base=0x010, L=4, N=1, buffer[0x10..0x13]=3,9,1,7, CP model=max -> rd_addr 0x10..0x13 contiguous; cp_enb high 4 cycles; wr_addr=dst_base, wr_data=9; done at start+8 cycles.
- Multi-window: L=3, N=3, dst_base=0x100 -> 3 writes at 0x100..0x102; cp_clr pulses exactly 3 times, each immediately before its window; done at start+19 cycles.
- Wrap: src_base=0x3FE, L=4, N=1 -> rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Config error: start with L=0, N=5 -> done pulse the next cycle, err=1, busy stays 0, and no rd_en/wr_en/cp_enb activity.
- Abort: abort asserted during FEED of window 1 (L=4, N=3) -> next cycle IDLE, cp_clr=1 for one cycle, no further rd_en/wr_en, no done. A new start afterwards runs the full job correctly.
- Reset and start-while-busy: a second start mid-job is ignored (write count equals the original N). resetn pulled low mid-FEED clears busy, rd_en and cp_enb asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/al_accel_pkg.sv
// Shared types and widths for the CP-unit sequencer and its address generator.
package al_accel_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int WIN_W  = 4;
    localparam int NWIN_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FEED  = 3'd2,
        TAIL  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] src_base;
        logic [ADDR_W-1:0] dst_base;
        logic [WIN_W-1:0]  win_len;
        logic [NWIN_W-1:0] num_win;
    } cfg_t;

endpackage

// File: rtl/al_accel_cp_addr_gen.sv
// Element/window counters and the source/destination address arithmetic.
// All address sums wrap at ADDR_W bits; the window offset k*L is formed as
// an ADDR_W-bit product so it wraps the same way.
module al_accel_cp_addr_gen
    import al_accel_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr_job,
    input  logic              clr_win,
    input  logic              inc_i,
    input  logic              inc_k,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [NWIN_W-1:0] num_win,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_elem,
    output logic              last_win
);

    logic [WIN_W-1:0]  i_q, i_d;
    logic [NWIN_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] win_off;

    // Counter next-state: i restarts every window, k restarts every job.
    always_comb begin
        i_d = i_q;
        k_d = k_q;
        if (clr_job || clr_win) begin
            i_d = '0;
        end else if (inc_i) begin
            i_d = i_q + WIN_W'(1);
        end
        if (clr_job) begin
            k_d = '0;
        end else if (inc_k) begin
            k_d = k_q + NWIN_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            k_q <= k_d;
        end
    end

    // Address and terminal-count decode.
    always_comb begin
        win_off   = ADDR_W'(k_q) * ADDR_W'(win_len);
        rd_addr   = src_base + win_off + ADDR_W'(i_q);
        wr_addr   = dst_base + ADDR_W'(k_q);
        last_elem = (i_q == (win_len - WIN_W'(1)));
        last_win  = (k_q == (num_win - NWIN_W'(1)));
    end

endmodule

// File: rtl/al_accel_cp_seq.sv
// Window sequencer for the CP pooling/compare unit.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; config latched on an accepted start
//   CLR   | clear CP accumulator, reset element counter
//   FEED  | issue L source reads, one per cycle
//   TAIL  | last read data is presented to the CP unit
//   WRITE | CP result written to destination, advance window
//   DONE  | one-cycle completion pulse (also the cfg-error exit)
//
// Read data returns one cycle after rd_en, so cp_enb is rd_en delayed by a
// register; cp_di is rd_data qualified by that delayed enable. A pending
// abort kills the delayed enable so an in-flight read never reaches the CP
// unit, and a one-cycle cp_clr is issued in IDLE to leave the unit clean.
module al_accel_cp_seq
    import al_accel_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
    input  logic [WIN_W-1:0]  cfg_win_len,
    input  logic [NWIN_W-1:0] cfg_num_win,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] cp_di,
    output logic              cp_enb,
    output logic              cp_clr,
    input  logic [DATA_W-1:0] cp_do,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    state_e state_q, state_d;
    cfg_t   cfg_q, cfg_d;
    logic   err_q, err_d;
    logic   cp_enb_q, cp_enb_d;
    logic   abort_clr_q, abort_clr_d;
    logic   clr_job, clr_win, inc_i, inc_k;
    logic   last_elem, last_win;

    al_accel_cp_addr_gen u_addr_gen (
        .clk       (clk),
        .resetn    (resetn),
        .clr_job   (clr_job),
        .clr_win   (clr_win),
        .inc_i     (inc_i),
        .inc_k     (inc_k),
        .src_base  (cfg_q.src_base),
        .dst_base  (cfg_q.dst_base),
        .win_len   (cfg_q.win_len),
        .num_win   (cfg_q.num_win),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr),
        .last_elem (last_elem),
        .last_win  (last_win)
    );

    // Next-state, config latch and counter control; abort overrides all.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        err_d       = err_q;
        abort_clr_d = 1'b0;
        clr_job     = 1'b0;
        clr_win     = 1'b0;
        inc_i       = 1'b0;
        inc_k       = 1'b0;
        cp_enb_d    = rd_en && !abort;
        if (abort) begin
            if (state_q != IDLE) begin
                state_d     = IDLE;
                abort_clr_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cfg_d.src_base = cfg_src_base;
                        cfg_d.dst_base = cfg_dst_base;
                        cfg_d.win_len  = cfg_win_len;
                        cfg_d.num_win  = cfg_num_win;
                        if ((cfg_win_len == '0) || (cfg_num_win == '0)) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            err_d   = 1'b0;
                            clr_job = 1'b1;
                            state_d = CLR;
                        end
                    end
                end
                CLR: begin
                    clr_win = 1'b1;
                    state_d = FEED;
                end
                FEED: begin
                    if (last_elem) begin
                        state_d = TAIL;
                    end else begin
                        inc_i = 1'b1;
                    end
                end
                TAIL: begin
                    state_d = WRITE;
                end
                WRITE: begin
                    if (last_win) begin
                        state_d = DONE;
                    end else begin
                        inc_k   = 1'b1;
                        state_d = CLR;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, latched config, error flag and data-alignment registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            err_q       <= 1'b0;
            cp_enb_q    <= 1'b0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            err_q       <= err_d;
            cp_enb_q    <= cp_enb_d;
            abort_clr_q <= abort_clr_d;
        end
    end

    // Outputs decoded from registered state so reset clears them at once.
    always_comb begin
        busy    = (state_q != IDLE) && !((state_q == DONE) && err_q);
        done    = (state_q == DONE);
        err     = err_q;
        rd_en   = (state_q == FEED);
        cp_clr  = (state_q == CLR) || abort_clr_q;
        cp_enb  = cp_enb_q;
        cp_di   = cp_enb_q ? rd_data : '0;
        wr_en   = (state_q == WRITE);
        wr_data = (state_q == WRITE) ? cp_do : '0;
    end

endmodule

// File: tb/tb_al_accel_cp_seq.sv
// Directed bench for al_accel_cp_seq with a synchronous SRAM model and a
// max-pooling CP unit model.
module tb_al_accel_cp_seq;
    import al_accel_pkg::*;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] cfg_src_base = '0;
    logic [ADDR_W-1:0] cfg_dst_base = '0;
    logic [WIN_W-1:0]  cfg_win_len = '0;
    logic [NWIN_W-1:0] cfg_num_win = '0;
    logic              busy, done, err, rd_en, cp_enb, cp_clr, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] cp_di, cp_do, wr_data;
    logic [DATA_W-1:0] acc = '0;

    logic [DATA_W-1:0] mem [0:1023];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int rd_n = 0, enb_n = 0, clr_n = 0, clr_rd_n = 0, wr_n = 0, done_n = 0;
    int done_cyc = 0;
    logic done_busy = 1'b0;
    logic prev_clr = 1'b0;
    logic [ADDR_W-1:0] rd_log [0:255];
    logic [ADDR_W-1:0] wa_log [0:63];
    logic [DATA_W-1:0] wd_log [0:63];

    always #5 clk = ~clk;

    al_accel_cp_seq dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_win_len  (cfg_win_len),
        .cfg_num_win  (cfg_num_win),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .cp_di        (cp_di),
        .cp_enb       (cp_enb),
        .cp_clr       (cp_clr),
        .cp_do        (cp_do),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    // Source SRAM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // CP unit model: running maximum.
    always @(posedge clk) begin
        if (cp_clr) acc <= '0;
        else if (cp_enb && (cp_di > acc)) acc <= cp_di;
    end
    assign cp_do = acc;

    always @(posedge clk) cyc <= cyc + 1;

    // Activity monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (rd_en) begin
            if (rd_n < 256) rd_log[rd_n] <= rd_addr;
            rd_n <= rd_n + 1;
        end
        if (cp_enb) enb_n <= enb_n + 1;
        if (cp_clr) clr_n <= clr_n + 1;
        if (prev_clr && rd_en) clr_rd_n <= clr_rd_n + 1;
        prev_clr <= cp_clr;
        if (wr_en) begin
            if (wr_n < 64) begin
                wa_log[wr_n] <= wr_addr;
                wd_log[wr_n] <= wr_data;
            end
            wr_n <= wr_n + 1;
        end
        if (done) begin
            done_n    <= done_n + 1;
            done_cyc  <= cyc;
            done_busy <= busy;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                            input logic [WIN_W-1:0] l, input logic [NWIN_W-1:0] n,
                            output int s);
        cfg_src_base = src;
        cfg_dst_base = dst;
        cfg_win_len  = l;
        cfg_num_win  = n;
        start = 1'b1;
        s = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int j = 0; j < budget && done_n == d0; j++) step(1);
        chk("done_seen", 32'(done_n != d0), 32'd1);
    endtask

    int s, r0, e0, c0, cr0, w0, d0;
    logic [ADDR_W-1:0] wrap_exp [0:3];
    logic [DATA_W-1:0] multi_exp [0:2];
    logic [DATA_W-1:0] abort_exp [0:2];

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = '0;
        mem[10'h010] = 8'd3; mem[10'h011] = 8'd9; mem[10'h012] = 8'd1; mem[10'h013] = 8'd7;
        mem[10'h020] = 8'd5; mem[10'h021] = 8'd2; mem[10'h022] = 8'd8;
        mem[10'h023] = 8'd1; mem[10'h024] = 8'd1; mem[10'h025] = 8'd0;
        mem[10'h026] = 8'd7; mem[10'h027] = 8'd9; mem[10'h028] = 8'd3;
        mem[10'h3FE] = 8'd4; mem[10'h3FF] = 8'd6; mem[10'h000] = 8'd2; mem[10'h001] = 8'd5;
        mem[10'h080] = 8'd10; mem[10'h081] = 8'd20; mem[10'h082] = 8'd30; mem[10'h083] = 8'd40;
        mem[10'h084] = 8'd50; mem[10'h085] = 8'd5;  mem[10'h086] = 8'd5;  mem[10'h087] = 8'd5;
        mem[10'h088] = 8'd1;  mem[10'h089] = 8'd2;  mem[10'h08A] = 8'd3;  mem[10'h08B] = 8'd4;
        wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
        multi_exp[0] = 8'd8; multi_exp[1] = 8'd1; multi_exp[2] = 8'd9;
        abort_exp[0] = 8'd40; abort_exp[1] = 8'd50; abort_exp[2] = 8'd4;

        // Reset state.
        #12;
        chk("reset_ctrl", 32'({busy, done, err, rd_en, cp_enb, cp_clr, wr_en}), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_data", 32'({wr_data, cp_di}), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        step(1);

        // Single window, L=4 N=1.
        r0 = rd_n; e0 = enb_n; w0 = wr_n; d0 = done_n;
        do_start(10'h010, 10'h200, 4'd4, 8'd1, s);
        wait_done(d0, 40);
        chk("single_rd_count", 32'(rd_n - r0), 32'd4);
        for (int j = 0; j < 4; j++) chk("single_rd_addr", 32'(rd_log[r0 + j]), 32'(10'h010 + j));
        chk("single_enb_count", 32'(enb_n - e0), 32'd4);
        chk("single_wr_count", 32'(wr_n - w0), 32'd1);
        chk("single_wr_addr", 32'(wa_log[w0]), 32'h200);
        chk("single_wr_data", 32'(wd_log[w0]), 32'd9);
        chk("single_done_time", 32'(done_cyc - s), 32'd8);
        chk("single_done_busy", 32'(done_busy), 32'd1);
        chk("single_err", 32'(err), 32'd0);

        // Multi-window, L=3 N=3.
        r0 = rd_n; c0 = clr_n; cr0 = clr_rd_n; w0 = wr_n; d0 = done_n;
        do_start(10'h020, 10'h100, 4'd3, 8'd3, s);
        wait_done(d0, 60);
        chk("multi_rd_count", 32'(rd_n - r0), 32'd9);
        chk("multi_wr_count", 32'(wr_n - w0), 32'd3);
        for (int j = 0; j < 3; j++) begin
            chk("multi_wr_addr", 32'(wa_log[w0 + j]), 32'(10'h100 + j));
            chk("multi_wr_data", 32'(wd_log[w0 + j]), 32'(multi_exp[j]));
        end
        chk("multi_clr_count", 32'(clr_n - c0), 32'd3);
        chk("multi_clr_before_feed", 32'(clr_rd_n - cr0), 32'd3);
        chk("multi_done_time", 32'(done_cyc - s), 32'd19);

        // Source address wrap.
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        do_start(10'h3FE, 10'h010, 4'd4, 8'd1, s);
        wait_done(d0, 40);
        for (int j = 0; j < 4; j++) chk("wrap_rd_addr", 32'(rd_log[r0 + j]), 32'(wrap_exp[j]));
        chk("wrap_wr_data", 32'(wd_log[w0]), 32'd6);

        // Config error, L=0.
        r0 = rd_n; e0 = enb_n; w0 = wr_n; d0 = done_n;
        do_start(10'h000, 10'h000, 4'd0, 8'd5, s);
        wait_done(d0, 10);
        chk("cfgerr_done_time", 32'(done_cyc - s), 32'd1);
        chk("cfgerr_done_busy", 32'(done_busy), 32'd0);
        chk("cfgerr_err", 32'(err), 32'd1);
        chk("cfgerr_activity", 32'((rd_n - r0) + (enb_n - e0) + (wr_n - w0)), 32'd0);
        step(3);
        chk("cfgerr_sticky", 32'(err), 32'd1);

        // Abort during FEED of window 1, L=4 N=3.
        r0 = rd_n; e0 = enb_n; c0 = clr_n; w0 = wr_n; d0 = done_n;
        do_start(10'h080, 10'h300, 4'd4, 8'd3, s);
        chk("abort_err_cleared", 32'(err), 32'd0);
        step(9);
        chk("abort_in_feed", 32'({busy, rd_en}), 32'b11);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_next_busy", 32'(busy), 32'd0);
        chk("abort_next_clr", 32'(cp_clr), 32'd1);
        chk("abort_next_rd_enb_wr", 32'({rd_en, cp_enb, wr_en}), 32'd0);
        step(1);
        chk("abort_clr_one_cycle", 32'(cp_clr), 32'd0);
        step(15);
        chk("abort_rd_count", 32'(rd_n - r0), 32'd6);
        chk("abort_enb_count", 32'(enb_n - e0), 32'd5);
        chk("abort_clr_count", 32'(clr_n - c0), 32'd3);
        chk("abort_wr_count", 32'(wr_n - w0), 32'd1);
        chk("abort_wr_data", 32'(wd_log[w0]), 32'd40);
        chk("abort_no_done", 32'(done_n - d0), 32'd0);

        // Full rerun after abort.
        w0 = wr_n; d0 = done_n;
        do_start(10'h080, 10'h300, 4'd4, 8'd3, s);
        wait_done(d0, 60);
        chk("rerun_wr_count", 32'(wr_n - w0), 32'd3);
        for (int j = 0; j < 3; j++) begin
            chk("rerun_wr_addr", 32'(wa_log[w0 + j]), 32'(10'h300 + j));
            chk("rerun_wr_data", 32'(wd_log[w0 + j]), 32'(abort_exp[j]));
        end
        chk("rerun_done_time", 32'(done_cyc - s), 32'd22);

        // Start while busy is ignored, L=2 N=2.
        w0 = wr_n; d0 = done_n;
        do_start(10'h080, 10'h340, 4'd2, 8'd2, s);
        step(3);
        cfg_src_base = 10'h000; cfg_dst_base = 10'h380; cfg_win_len = 4'd7; cfg_num_win = 8'd9;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(d0, 40);
        chk("busy_start_wr_count", 32'(wr_n - w0), 32'd2);
        chk("busy_start_wr_addr0", 32'(wa_log[w0]), 32'h340);
        chk("busy_start_wr_addr1", 32'(wa_log[w0 + 1]), 32'h341);
        chk("busy_start_wr_data0", 32'(wd_log[w0]), 32'd20);
        chk("busy_start_wr_data1", 32'(wd_log[w0 + 1]), 32'd40);
        chk("busy_start_done_time", 32'(done_cyc - s), 32'd11);

        // Asynchronous reset mid-FEED.
        do_start(10'h080, 10'h340, 4'd4, 8'd2, s);
        step(2);
        chk("rst_pre_feed", 32'({busy, rd_en, cp_enb}), 32'b111);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'({busy, rd_en, cp_enb}), 32'd0);
        chk("rst_async_rd_addr", 32'(rd_addr), 32'd0);
        step(2);
        resetn = 1'b1;
        step(1);
        chk("rst_after_idle", 32'({busy, done, err}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
